// File: rtl/rle1_dec.sv
// ---------------------------------------------------------------------------
// rle1_dec -- run-length decoder for 2-bit symbols.
//
// Accepts 6-bit run tokens {count[3:0], symbol[1:0]} and expands each into
// `count` consecutive output beats of `symbol`. Both sides use valid/ready
// handshakes; a beat transfers whenever vld and rdy are high at a rising clk.
// Count-0 tokens are consumed and produce nothing.
//
// Configuration macro: RLE1_DEC_CHAIN_EN
//   undefined : input is only ready in IDLE, so each run is followed by one
//               idle cycle before the next token can be taken.
//   defined   : on the last beat of a run, the next token is accepted in the
//               same cycle, so consecutive runs stream without a bubble.
//
// Ports
//   clk                 in   clock, rising edge
//   reset               in   asynchronous active-high reset
//   rle1__input_r       in   [5:2] run count, [1:0] symbol
//   rle1__input_r_vld   in   token valid
//   rle1__input_r_rdy   out  decoder can accept a token
//   rle1__output_s      out  decoded symbol
//   rle1__output_s_vld  out  symbol valid
//   rle1__output_s_rdy  in   downstream accepts the symbol
// ---------------------------------------------------------------------------
module rle1_dec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] rle1__input_r,
  input  logic       rle1__input_r_vld,
  output logic       rle1__input_r_rdy,
  output logic [1:0] rle1__output_s,
  output logic       rle1__output_s_vld,
  input  logic       rle1__output_s_rdy
);

  localparam int unsigned SYM_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  // Cleared by reset, set on the first edge after release: keeps the input
  // side closed while reset is held even though the state reads IDLE.
  logic               armed_q;

  logic [SYM_W-1:0]   tok_sym;
  logic [CNT_W-1:0]   tok_cnt;
  logic               in_hs;
  logic               out_hs;
  logic               last_beat;

  assign tok_sym   = rle1__input_r[SYM_W-1:0];
  assign tok_cnt   = rle1__input_r[SYM_W+CNT_W-1:SYM_W];
  assign in_hs     = rle1__input_r_vld & rle1__input_r_rdy;
  assign out_hs    = rle1__output_s_vld & rle1__output_s_rdy;
  assign last_beat = (rem_q == CNT_W'(1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      rem_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      rem_q   <= rem_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs && (tok_cnt != '0)) begin
          sym_d   = tok_sym;
          rem_d   = tok_cnt;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (!last_beat) begin
            rem_d = rem_q - CNT_W'(1);
          end else if (in_hs && (tok_cnt != '0)) begin
            // Chained token: reload and keep emitting with no gap.
            sym_d = tok_sym;
            rem_d = tok_cnt;
          end else begin
            rem_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs, decoded from the current state.
  always_comb begin
    rle1__input_r_rdy  = 1'b0;
    rle1__output_s_vld = 1'b0;
    rle1__output_s     = sym_q;
    unique case (state_q)
      IDLE: begin
        rle1__input_r_rdy = armed_q;
      end
      EMIT: begin
        rle1__output_s_vld = 1'b1;
`ifdef RLE1_DEC_CHAIN_EN
        rle1__input_r_rdy  = last_beat & rle1__output_s_rdy;
`else
        rle1__input_r_rdy  = 1'b0;
`endif
      end
      default: begin
        rle1__input_r_rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rle1_dec.sv
// ---------------------------------------------------------------------------
// tb_rle1_dec -- self-checking bench for rle1_dec. A queue holds the symbols
// the reference expansion still owes; every output handshake pops it, and
// ready/valid are predicted from how much is still owed.
// ---------------------------------------------------------------------------
module tb_rle1_dec;

  logic       clk;
  logic       reset;
  logic [5:0] in_tok;
  logic       in_vld;
  logic       in_rdy;
  logic [1:0] out_sym;
  logic       out_vld;
  logic       out_rdy;

  rle1_dec dut (
    .clk                (clk),
    .reset              (reset),
    .rle1__input_r      (in_tok),
    .rle1__input_r_vld  (in_vld),
    .rle1__input_r_rdy  (in_rdy),
    .rle1__output_s     (out_sym),
    .rle1__output_s_vld (out_vld),
    .rle1__output_s_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc_n  = 0;
  int         acc_cyc = 0;
  logic [1:0] exp_q[$];
  int         hs_cyc[$];
  logic       prev_stall = 1'b0;
  logic [1:0] prev_sym   = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, update model, advance.
  task automatic cyc(input logic tv, input logic [5:0] tok, input logic ordy, output logic acc);
    logic exp_rdy;
    in_vld  = tv;
    in_tok  = tok;
    out_rdy = ordy;
    @(negedge clk);
    chk("out_vld", 32'(out_vld), 32'(exp_q.size() != 0));
`ifdef RLE1_DEC_CHAIN_EN
    exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
`else
    exp_rdy = (exp_q.size() == 0);
`endif
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    if (prev_stall) begin
      chk("stall_vld", 32'(out_vld), 32'd1);
      chk("stall_sym", 32'(out_sym), 32'(prev_sym));
    end
    if (out_vld && ordy) begin
      hs_cyc.push_back(cyc_n);
      if (exp_q.size() != 0) begin
        chk("sym", 32'(out_sym), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    acc = tv && in_rdy;
    if (acc) begin
      acc_cyc = cyc_n;
      for (int i = 0; i < int'(tok[5:2]); i++) exp_q.push_back(tok[1:0]);
    end
    prev_stall = out_vld && !ordy;
    prev_sym   = out_sym;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic send_token(input logic [3:0] cnt, input logic [1:0] sym, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cyc(1'b1, {cnt, sym}, ordy, acc);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: rdy low, 1: rdy high, 2: toggle 1,0,.. from acceptance, 3: random
  task automatic idle(input int n, input int mode);
    logic acc;
    logic r;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = ((cyc_n - acc_cyc) % 2) == 1;
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      cyc(1'b0, 6'd0, r, acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [5:0] tok;
    int         k;

    // Reset state, asynchronous and before any clock edge.
    reset   = 1'b1;
    in_vld  = 1'b0;
    in_tok  = 6'd0;
    out_rdy = 1'b0;
    #3;
    chk("rst_rdy", 32'(in_rdy), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_sym", 32'(out_sym), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rdy_held", 32'(in_rdy), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", 32'(in_rdy), 32'd1);
    chk("post_rst_vld", 32'(out_vld), 32'd0);

    // Run of 3 x symbol 2 on consecutive cycles after acceptance.
    hs_cyc.delete();
    send_token(4'd3, 2'd2, 1'b1);
    k = acc_cyc;
    idle(5, 1);
    chk("run3_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      chk("run3_first", 32'(hs_cyc[0]), 32'(k + 1));
      chk("run3_last", 32'(hs_cyc[2]), 32'(k + 3));
    end

    // Count-0 token is swallowed without output.
    hs_cyc.delete();
    k = cyc_n;
    send_token(4'd0, 2'd1, 1'b1);
    chk("zero_acc_cyc", 32'(acc_cyc), 32'(k));
    idle(4, 1);
    chk("zero_no_out", 32'(hs_cyc.size()), 32'd0);

    // 15 x symbol 3 against a toggling downstream.
    hs_cyc.delete();
    send_token(4'd15, 2'd3, 1'b1);
    idle(40, 2);
    chk("run15_count", 32'(hs_cyc.size()), 32'd15);

    // Back-to-back runs: bubble only without chaining.
    hs_cyc.delete();
    send_token(4'd2, 2'd1, 1'b1);
    k = acc_cyc;
    send_token(4'd1, 2'd0, 1'b1);
    idle(4, 1);
    chk("b2b_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_second", 32'(hs_cyc[1]), 32'(k + 2));
`ifdef RLE1_DEC_CHAIN_EN
      chk("b2b_third", 32'(hs_cyc[2]), 32'(k + 3));
`else
      chk("b2b_third", 32'(hs_cyc[2]), 32'(k + 4));
`endif
    end

    // Abort a 5-run after 2 symbols with an asynchronous reset.
    hs_cyc.delete();
    send_token(4'd5, 2'd2, 1'b1);
    for (int i = 0; i < 16 && hs_cyc.size() < 2; i++) cyc(1'b0, 6'd0, 1'b1, acc);
    chk("abort_two_done", 32'(hs_cyc.size()), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_vld_drop", 32'(out_vld), 32'd0);
    chk("abort_rdy_low", 32'(in_rdy), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_vld_held", 32'(out_vld), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rel_rdy", 32'(in_rdy), 32'd1);
    hs_cyc.delete();
    send_token(4'd2, 2'd1, 1'b1);
    idle(4, 1);
    chk("abort_next_count", 32'(hs_cyc.size()), 32'd2);

    // Random tokens (count 0 included) against random downstream readiness.
    hs_cyc.delete();
    tok = 6'd0;
    for (int i = 0; i < 600; i++) begin
      logic tv;
      if (i == 0 || acc) begin
        tok[1:0] = 2'($urandom_range(0, 3));
        tok[5:2] = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      tv = ($urandom_range(0, 3) != 0);
      cyc(tv, tok, ($urandom_range(0, 2) != 0), acc);
    end
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) cyc(1'b0, 6'd0, 1'b1, acc);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_activity", 32'(hs_cyc.size() > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle1_dec.md
RLE1_DEC -- requirements
Module: rle1_dec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port rle1__input_r, input, 6 bits: run token; [1:0] = symbol, [5:2] = run count (0..15).
REQ-004 SHALL have port rle1__input_r_vld, input, 1 bit: token valid.
REQ-005 SHALL have port rle1__input_r_rdy, output, 1 bit: decoder can accept a token.
REQ-006 SHALL have port rle1__output_s, output, 2 bits: decoded symbol.
REQ-007 SHALL have port rle1__output_s_vld, output, 1 bit: symbol valid.
REQ-008 SHALL have port rle1__output_s_rdy, input, 1 bit: downstream accepts the symbol.

Function
REQ-009 Handshakes SHALL occur on any cycle where vld and rdy are both high at the rising edge of clk; vld/rdy SHALL be independent and neither SHALL wait for the other.
REQ-010 FSM SHALL have two states, IDLE and EMIT; registers: sym[1:0], remaining[3:0].
REQ-011 IDLE: rle1__input_r_rdy=1, rle1__output_s_vld=0.
REQ-012 IDLE + input handshake with count != 0: sym <= token[1:0], remaining <= count, next state EMIT.
REQ-013 IDLE + input handshake with count == 0: token consumed and discarded, no output, stay in IDLE.
REQ-014 EMIT: rle1__output_s_vld=1 and rle1__output_s=sym; remaining SHALL NOT change without an output handshake.
REQ-015 EMIT + output handshake with remaining > 1: remaining decrements by 1, stay in EMIT.
REQ-016 EMIT + output handshake with remaining == 1: next state IDLE (subject to REQ-022).
REQ-017 Latency: first symbol valid on the cycle after token acceptance; a run of count N yields exactly N output handshakes of the same symbol.
REQ-018 rle1__output_s and rle1__output_s_vld SHALL be held stable while output_s_vld=1 and output_s_rdy=0.
REQ-019 In EMIT, rle1__input_r_rdy SHALL be 0, except where REQ-022 applies.

Reset
REQ-020 While reset=1: state=IDLE, sym=0, remaining=0, rle1__output_s=0, rle1__output_s_vld=0, rle1__input_r_rdy=0; effect immediate, independent of clk.
REQ-021 Reset asserted mid-run SHALL abandon the run (remaining symbols are lost); after deassertion, rle1__input_r_rdy=1 from the first clk edge.

Configuration
REQ-022 Macro RLE1_DEC_CHAIN_EN defined: in EMIT, rle1__input_r_rdy = (remaining==1) && rle1__output_s_rdy. A token accepted in that cycle loads sym/remaining directly and stays in EMIT, so there is no bubble between runs. A count-0 token accepted there goes to IDLE.
REQ-023 RLE1_DEC_CHAIN_EN undefined: rle1__input_r_rdy=0 throughout EMIT; each nonzero token costs count+1 cycles at full downstream rate.

Verification
REQ-024 Reset, then token {count=3, sym=2} with output_s_rdy=1: output 2,2,2 on three consecutive cycles starting the cycle after acceptance, then vld=0.
REQ-025 Token {count=0, sym=1}: accepted, no output_s_vld pulse, input_r_rdy stays 1.
REQ-026 Token {count=15, sym=3} with output_s_rdy toggling 1,0,1,0...: exactly 15 handshakes of value 3, data stable while stalled.
REQ-027 Tokens {2,sym=1} and {1,sym=0} back-to-back, output_s_rdy=1: without macro, output 1,1,-,0 (one bubble); with RLE1_DEC_CHAIN_EN, output 1,1,0 (no bubble).
REQ-028 Assert reset asynchronously after 2 of 5 symbols: output_s_vld drops immediately; after release, the next token decodes correctly with no residue from the aborted run.
REQ-029 Random tokens (including count 0) against a random output_s_rdy pattern: the output stream SHALL equal the reference expansion in both macro builds.
